// File: rtl/fixed_relu_requant.sv
// rtl/fixed_relu_requant.sv - pipelined multi-lane ReLU / clipped ReLU / leaky ReLU with fixed-point requantisation
module fixed_relu_requant #(
    parameter int DATA_IN_0_PRECISION_0       = 8,
    parameter int DATA_IN_0_PRECISION_1       = 4,
    parameter int DATA_OUT_0_PRECISION_0      = 8,
    parameter int DATA_OUT_0_PRECISION_1      = 4,
    parameter int DATA_IN_0_TENSOR_SIZE_DIM_0 = 8,
    parameter int DATA_IN_0_TENSOR_SIZE_DIM_1 = 1,
    parameter int DATA_IN_0_PARALLELISM_DIM_0 = 1,
    parameter int DATA_IN_0_PARALLELISM_DIM_1 = 1,
    parameter int MODE                        = 0,
    parameter int CLIP_INT                    = 6,
    parameter int LEAKY_SHIFT                 = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic [DATA_IN_0_PRECISION_0*DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1-1:0]  data_in_0,
    input  logic data_in_0_valid,
    output logic data_in_0_ready,
    output logic [DATA_OUT_0_PRECISION_0*DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1-1:0] data_out_0,
    output logic data_out_0_valid,
    input  logic data_out_0_ready,
    output logic data_out_0_last
);

    localparam int W_IN  = DATA_IN_0_PRECISION_0;
    localparam int F_IN  = DATA_IN_0_PRECISION_1;
    localparam int W_OUT = DATA_OUT_0_PRECISION_0;
    localparam int F_OUT = DATA_OUT_0_PRECISION_1;
    localparam int N     = DATA_IN_0_PARALLELISM_DIM_0 * DATA_IN_0_PARALLELISM_DIM_1;
    localparam int BEATS = (DATA_IN_0_TENSOR_SIZE_DIM_0 / DATA_IN_0_PARALLELISM_DIM_0)
                         * (DATA_IN_0_TENSOR_SIZE_DIM_1 / DATA_IN_0_PARALLELISM_DIM_1);
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    // Requantisation shift: positive D widens the fraction, negative D rounds it away.
    localparam int D     = F_OUT - F_IN;
    localparam int SH_L  = (D > 0) ? D : 0;
    localparam int SH_R  = (D < 0) ? -D : 0;
    localparam int W_INT = W_IN + SH_L + 1;
    localparam int RND   = (1 << SH_R) >> 1;
    localparam logic signed [W_INT-1:0] RND_W = W_INT'(RND);

    // Saturation bounds, evaluated in 64 bits so large clip values cannot wrap.
    localparam longint OUT_MAX   = (longint'(1) <<< (W_OUT - 1)) - 1;
    localparam longint OUT_MIN   = -(longint'(1) <<< (W_OUT - 1));
    localparam longint CLIP_FULL = longint'(CLIP_INT) <<< F_OUT;
    localparam longint CEIL      = (MODE == 1 && CLIP_FULL < OUT_MAX) ? CLIP_FULL : OUT_MAX;

    generate
        if (MODE < 0 || MODE > 2) begin : g_bad_mode
            $error("fixed_relu_requant: MODE must be 0, 1 or 2");
        end
    endgenerate

    logic                   s1_valid;
    logic [W_IN*N-1:0]      s1_data;
    logic                   s2_valid;
    logic                   s1_accept;
    logic                   s2_accept;
    logic [CNT_W-1:0]       beat_cnt;

    // Activation on one lane; clipping for MODE 1 is folded into saturation later.
    function automatic logic [W_IN-1:0] act(input logic [W_IN-1:0] a);
        logic signed [W_IN-1:0] x;
        x = signed'(a);
        if (MODE == 2) begin
            return a[W_IN-1] ? (x >>> LEAKY_SHIFT) : x;
        end
        return a[W_IN-1] ? '0 : a;
    endfunction

    // Format conversion with round-half-up and saturation on one lane.
    function automatic logic [W_OUT-1:0] requant(input logic [W_IN-1:0] a);
        logic signed [W_INT-1:0] t;
        logic signed [63:0]      w;
        t = {{(W_INT-W_IN){a[W_IN-1]}}, a};
        if (D < 0) begin
            t = (t + RND_W) >>> SH_R;
        end else begin
            t = t <<< SH_L;
        end
        w = {{(64-W_INT){t[W_INT-1]}}, t};
        if (w > CEIL) begin
            w = CEIL;
        end else if (w < OUT_MIN) begin
            w = OUT_MIN;
        end
        return w[W_OUT-1:0];
    endfunction

    assign s2_accept        = !s2_valid || data_out_0_ready;
    assign s1_accept        = !s1_valid || s2_accept;
    assign data_in_0_ready  = s1_accept;
    assign data_out_0_valid = s2_valid;
    assign data_out_0_last  = s2_valid && (beat_cnt == CNT_W'(BEATS - 1));

    // Stage 1: capture the activated beat whenever the slot is free or draining.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else if (s1_accept) begin
            s1_valid <= data_in_0_valid;
            if (data_in_0_valid) begin
                for (int i = 0; i < N; i++) begin
                    s1_data[i*W_IN +: W_IN] <= act(data_in_0[i*W_IN +: W_IN]);
                end
            end
        end
    end

    // Stage 2: requantise into the output register; holds while downstream stalls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_valid   <= 1'b0;
            data_out_0 <= '0;
        end else if (s2_accept) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                for (int i = 0; i < N; i++) begin
                    data_out_0[i*W_OUT +: W_OUT] <= requant(s1_data[i*W_IN +: W_IN]);
                end
            end
        end
    end

    // Beat position within the tensor, advanced on each output handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat_cnt <= '0;
        end else if (s2_valid && data_out_0_ready) begin
            beat_cnt <= (beat_cnt == CNT_W'(BEATS - 1)) ? '0 : beat_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fixed_relu_requant.sv
// tb/tb_fixed_relu_requant.sv - table-driven scoreboard bench for fixed_relu_requant
module tb_fixed_relu_requant;

    localparam int NI = 6;
    localparam int NV = 15;

    typedef struct packed {
        logic [7:0]      x;
        logic [5:0][7:0] e;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic       vin;
    logic       rout = 1'b1;
    logic       rdy  [NI];
    logic       vout [NI];
    logic       last [NI];
    logic [7:0] dout [NI];
    logic [3:0] dout_e;

    logic [15:0] g_din;
    logic        g_vin;
    logic        g_rdy;
    logic [15:0] g_dout;
    logic        g_vout;
    logic        g_rout;
    logic        g_last;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    vec_t tbl [NV];

    int   q_idx [$];
    int   q_cyc [$];
    bit   q_lat [$];
    int   cur_idx;
    bit   lat_mode;
    bit   mon_on;
    bit   stall_on;
    int   stall_at;
    bit   saw_low;
    int   last_cnt = 0;
    bit   held = 0;
    logic [7:0] held_d [NI];
    logic held_l;

    assign dout[4] = {4'h0, dout_e};

    fixed_relu_requant #(.MODE(0)) u_a (
        .clk(clk), .rst(rst), .data_in_0(din), .data_in_0_valid(vin), .data_in_0_ready(rdy[0]),
        .data_out_0(dout[0]), .data_out_0_valid(vout[0]), .data_out_0_ready(rout), .data_out_0_last(last[0]));
    fixed_relu_requant #(.MODE(1), .CLIP_INT(6)) u_b (
        .clk(clk), .rst(rst), .data_in_0(din), .data_in_0_valid(vin), .data_in_0_ready(rdy[1]),
        .data_out_0(dout[1]), .data_out_0_valid(vout[1]), .data_out_0_ready(rout), .data_out_0_last(last[1]));
    fixed_relu_requant #(.MODE(2), .LEAKY_SHIFT(3)) u_c (
        .clk(clk), .rst(rst), .data_in_0(din), .data_in_0_valid(vin), .data_in_0_ready(rdy[2]),
        .data_out_0(dout[2]), .data_out_0_valid(vout[2]), .data_out_0_ready(rout), .data_out_0_last(last[2]));
    fixed_relu_requant #(.MODE(2), .LEAKY_SHIFT(1), .DATA_OUT_0_PRECISION_1(2)) u_d (
        .clk(clk), .rst(rst), .data_in_0(din), .data_in_0_valid(vin), .data_in_0_ready(rdy[3]),
        .data_out_0(dout[3]), .data_out_0_valid(vout[3]), .data_out_0_ready(rout), .data_out_0_last(last[3]));
    fixed_relu_requant #(.MODE(0), .DATA_OUT_0_PRECISION_0(4), .DATA_OUT_0_PRECISION_1(0)) u_e (
        .clk(clk), .rst(rst), .data_in_0(din), .data_in_0_valid(vin), .data_in_0_ready(rdy[4]),
        .data_out_0(dout_e), .data_out_0_valid(vout[4]), .data_out_0_ready(rout), .data_out_0_last(last[4]));
    fixed_relu_requant #(.MODE(0), .DATA_OUT_0_PRECISION_1(6)) u_f (
        .clk(clk), .rst(rst), .data_in_0(din), .data_in_0_valid(vin), .data_in_0_ready(rdy[5]),
        .data_out_0(dout[5]), .data_out_0_valid(vout[5]), .data_out_0_ready(rout), .data_out_0_last(last[5]));
    fixed_relu_requant #(.MODE(0), .DATA_IN_0_TENSOR_SIZE_DIM_0(8), .DATA_IN_0_PARALLELISM_DIM_0(2)) u_g (
        .clk(clk), .rst(rst), .data_in_0(g_din), .data_in_0_valid(g_vin), .data_in_0_ready(g_rdy),
        .data_out_0(g_dout), .data_out_0_valid(g_vout), .data_out_0_ready(g_rout), .data_out_0_last(g_last));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) rout = !(stall_on && cyc >= stall_at && cyc < stall_at + 3);

    initial begin
        #500000;
        $display("FAIL global_timeout: sim still running at %0t, required finish earlier", $time);
        $fatal(1, "bench timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] x, a, b, c, d, e, f);
        vec_t v;
        v.x = x;
        v.e[0] = a; v.e[1] = b; v.e[2] = c; v.e[3] = d; v.e[4] = e; v.e[5] = f;
        return v;
    endfunction

    // Scoreboard: sampled mid-cycle, just before the edge that performs the handshakes.
    always @(negedge clk) begin
        logic exp_rdy;
        int   idx;
        int   pc;
        bit   pl;
        #3;
        if (!rst) begin
            q_idx.delete(); q_cyc.delete(); q_lat.delete();
            last_cnt = 0;
            held = 0;
        end else if (mon_on) begin
            exp_rdy = !(q_idx.size() == 2 && !rout);
            for (int k = 0; k < NI; k++) begin
                check($sformatf("in_ready[%0d]", k), rdy[k], exp_rdy);
            end
            if (stall_on && !rdy[0]) saw_low = 1;
            if (held) begin
                for (int k = 0; k < NI; k++) begin
                    check($sformatf("hold_data[%0d]", k), dout[k], held_d[k]);
                end
                check("hold_valid", vout[0], 1);
                check("hold_last", last[0], held_l);
            end
            for (int k = 1; k < NI; k++) begin
                check($sformatf("valid_agree[%0d]", k), vout[k], vout[0]);
                check($sformatf("last_agree[%0d]", k), last[k], last[0]);
            end
            check("last_flag", last[0], vout[0] && last_cnt == 7);
            if (vout[0] && q_idx.size() == 0) begin
                check("no_extra_beat", vout[0], 0);
            end else if (vout[0] && rout) begin
                idx = q_idx.pop_front();
                pc  = q_cyc.pop_front();
                pl  = q_lat.pop_front();
                for (int k = 0; k < NI; k++) begin
                    check($sformatf("dout[%0d] x=%0h", k, tbl[idx].x), dout[k], tbl[idx].e[k]);
                end
                if (pl) check($sformatf("latency x=%0h", tbl[idx].x), cyc - pc, 2);
                last_cnt = (last_cnt == 7) ? 0 : last_cnt + 1;
            end
            held = vout[0] && !rout;
            for (int k = 0; k < NI; k++) held_d[k] = dout[k];
            held_l = last[0];
            if (vin && rdy[0]) begin
                q_idx.push_back(cur_idx);
                q_cyc.push_back(cyc);
                q_lat.push_back(lat_mode);
            end
        end
    end

    task automatic send(input int idx);
        int t;
        t = 0;
        cur_idx = idx;
        din = tbl[idx].x;
        vin = 1'b1;
        #1;
        while (!rdy[0] && t < 50) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (t >= 50) check("send_timeout", rdy[0], 1);
        @(negedge clk);
    endtask

    task automatic drain();
        for (int t = 0; t < 30 && q_idx.size() != 0; t++) @(negedge clk);
        check("drain_pending", q_idx.size(), 0);
    endtask

    initial begin
        rst = 1'b0; vin = 1'b0; din = '0; cur_idx = 0;
        g_din = '0; g_vin = 1'b0; g_rout = 1'b1;
        stall_on = 0; stall_at = 0; lat_mode = 1; mon_on = 0; saw_low = 0;

        //            x      relu   clip   leaky3 lk1F2  W4F0   F6
        tbl[0]  = mk(8'h90, 8'h00, 8'h00, 8'hF2, 8'hF2, 8'h00, 8'h00);
        tbl[1]  = mk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        tbl[2]  = mk(8'h35, 8'h35, 8'h35, 8'h35, 8'h0D, 8'h03, 8'h7F);
        tbl[3]  = mk(8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 8'h00, 8'h04);
        tbl[4]  = mk(8'hF0, 8'h00, 8'h00, 8'hFE, 8'hFE, 8'h00, 8'h00);
        tbl[5]  = mk(8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00);
        tbl[6]  = mk(8'h20, 8'h20, 8'h20, 8'h20, 8'h08, 8'h02, 8'h7F);
        tbl[7]  = mk(8'h70, 8'h70, 8'h60, 8'h70, 8'h1C, 8'h07, 8'h7F);
        tbl[8]  = mk(8'h60, 8'h60, 8'h60, 8'h60, 8'h18, 8'h06, 8'h7F);
        tbl[9]  = mk(8'h50, 8'h50, 8'h50, 8'h50, 8'h14, 8'h05, 8'h7F);
        tbl[10] = mk(8'hC0, 8'h00, 8'h00, 8'hF8, 8'hF8, 8'h00, 8'h00);
        tbl[11] = mk(8'h36, 8'h36, 8'h36, 8'h36, 8'h0E, 8'h03, 8'h7F);
        tbl[12] = mk(8'h7F, 8'h7F, 8'h60, 8'h7F, 8'h20, 8'h07, 8'h7F);
        tbl[13] = mk(8'h30, 8'h30, 8'h30, 8'h30, 8'h0C, 8'h03, 8'h7F);
        tbl[14] = mk(8'hFC, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00);

        repeat (2) @(negedge clk);
        #3;
        for (int k = 0; k < NI; k++) begin
            check($sformatf("reset_valid[%0d]", k), vout[k], 0);
            check($sformatf("reset_data[%0d]", k), dout[k], 0);
            check($sformatf("reset_last[%0d]", k), last[k], 0);
        end
        check("reset_g_valid", g_vout, 0);
        check("reset_g_data", g_dout, 0);
        @(negedge clk);
        rst = 1'b1;
        mon_on = 1;

        // Back-to-back stream through every configuration, latency checked.
        for (int i = 0; i < NV; i++) send(i);
        vin = 1'b0;
        drain();

        // Backpressure: downstream stalls for 3 cycles mid-stream.
        lat_mode = 0;
        stall_at = cyc + 3;
        stall_on = 1;
        for (int i = 2; i < 8; i++) send(i);
        vin = 1'b0;
        drain();
        stall_on = 0;
        check("ready_dropped", saw_low, 1);

        // Two-lane instance, 4 beats per tensor: last on beats 4 and 8.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i < 8) begin
                g_din = {8'h80 | 8'(i), 8'h10 + 8'(i)};
                g_vin = 1'b1;
            end else begin
                g_vin = 1'b0;
            end
            #3;
            check($sformatf("g_ready i=%0d", i), g_rdy, 1);
            if (i >= 2) begin
                check($sformatf("g_valid beat%0d", i - 2), g_vout, 1);
                check($sformatf("g_data beat%0d", i - 2), g_dout, {8'h00, 8'h10 + 8'(i - 2)});
                check($sformatf("g_last beat%0d", i - 2), g_last, ((i - 2) % 4) == 3);
            end else begin
                check($sformatf("g_idle i=%0d", i), g_vout, 0);
            end
        end

        // Async reset with the third beat on the output and a fourth in flight.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i < 4) begin
                g_din = {8'h00, 8'h20 + 8'(i)};
                g_vin = 1'b1;
            end else begin
                g_vin = 1'b0;
            end
            #3;
            if (i >= 2) begin
                check($sformatf("pre_rst_valid beat%0d", i - 2), g_vout, 1);
                check($sformatf("pre_rst_last beat%0d", i - 2), g_last, 0);
            end
        end
        #1;
        rst = 1'b0;
        #1;
        check("async_rst_valid", g_vout, 0);
        check("async_rst_last", g_last, 0);
        check("async_rst_data", g_dout, 0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i < 4) begin
                g_din = {8'h00, 8'h40 + 8'(i)};
                g_vin = 1'b1;
            end else begin
                g_vin = 1'b0;
            end
            #3;
            if (i >= 2) begin
                check($sformatf("post_rst_data beat%0d", i - 2), g_dout, {8'h00, 8'h40 + 8'(i - 2)});
                check($sformatf("post_rst_last beat%0d", i - 2), g_last, (i - 2) == 3);
            end else begin
                check($sformatf("post_rst_no_stale i=%0d", i), g_vout, 0);
            end
        end
        @(negedge clk);
        #3;
        check("post_rst_drained", g_vout, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fixed_relu_requant.md
Name: fixed_relu_requant

Overview:
Pipelined, parametrised successor to the combinational fixed-point ReLU, used between linear/conv layers in the dataflow graph. It applies one of three activation modes to every lane of a parallel beat: ReLU, clipped ReLU, or leaky ReLU with a shift slope. It requantises each result from the input fixed-point format to the output format with round-half-up and saturation. It registers the stream through a 2-stage valid/ready pipeline and flags the last beat of each tensor.

Parameters:
DATA_IN_0_PRECISION_0, 8, input word width W_IN (signed two's complement)
DATA_IN_0_PRECISION_1, 4, input fraction bits F_IN
DATA_OUT_0_PRECISION_0, 8, output word width W_OUT
DATA_OUT_0_PRECISION_1, 4, output fraction bits F_OUT
DATA_IN_0_TENSOR_SIZE_DIM_0, 8, tensor size dim 0 (multiple of PARALLELISM_DIM_0)
DATA_IN_0_TENSOR_SIZE_DIM_1, 1, tensor size dim 1 (multiple of PARALLELISM_DIM_1)
DATA_IN_0_PARALLELISM_DIM_0, 1, lanes per beat, dim 0
DATA_IN_0_PARALLELISM_DIM_1, 1, lanes per beat, dim 1
MODE, 0, 0 = ReLU, 1 = clipped ReLU, 2 = leaky ReLU (3 is illegal; elaboration error)
CLIP_INT, 6, integer clip ceiling for MODE 1 (ceiling = CLIP_INT << F_OUT, saturated)
LEAKY_SHIFT, 3, negative slope = 2^-LEAKY_SHIFT for MODE 2

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset
data_in_0  input  W_IN x N  input lanes, N = PAR_DIM_0*PAR_DIM_1
data_in_0_valid  input  1  input beat valid
data_in_0_ready  output  1  input beat accepted when valid&&ready
data_out_0  output  W_OUT x N  output lanes
data_out_0_valid  output  1  output beat valid
data_out_0_ready  input  1  downstream ready
data_out_0_last  output  1  high with the final beat of each tensor

Behaviour:
- Reset (rst=0, async assert, sync release): s1_valid=s2_valid=0; data_out_0_valid=0; data_out_0 all lanes 0; data_out_0_last=0; beat counter=0. In-flight beats are discarded. No output handshake occurs while in reset.
- Stage 1, per lane, computed on input handshake and registered at width W_IN:
  - MODE 0: x<=0 gives 0, otherwise x.
  - MODE 1: same as MODE 0; the clip is applied in stage 2.
  - MODE 2: x>=0 gives x, otherwise x>>>LEAKY_SHIFT (arithmetic shift, floor; e.g. -1 gives -1).
- Stage 2, per lane, requantisation:
  - D = F_OUT - F_IN.
  - D >= 0: shift left by D.
  - D < 0: add 2^(-D-1), then arithmetic shift right by -D (round half up, so -0.5 rounds to 0).
  - Internal width is W_IN + max(D,0) + 1, so nothing is lost before saturation.
  - Saturate to [-2^(W_OUT-1), 2^(W_OUT-1)-1].
  - MODE 1: additionally clamp the upper bound to min(CLIP_INT<<F_OUT, 2^(W_OUT-1)-1).
- Handshake: each stage holds one beat.
  - s2 accepts a beat when !s2_valid || data_out_0_ready.
  - s1 accepts a beat when !s1_valid || s2 accepting.
  - data_in_0_ready = s1 accepting.
  - The ready path is combinational.
- Latency: 2 cycles from input handshake to data_out_0_valid with no backpressure. Throughput is 1 beat/cycle.
- Under backpressure, data_out_0 and data_out_0_last stay stable while valid&&!ready. No beat is dropped or duplicated, and order is preserved.
- Beat counter: BEATS = (DIM_0/PAR_0)*(DIM_1/PAR_1).
  - Counts output handshakes and wraps from BEATS-1 to 0.
  - data_out_0_last = data_out_0_valid && count==BEATS-1.
  - BEATS=1 means every beat is last.
- Simultaneous input and output handshake with both stages full: all stages advance in the same cycle with no bubble.
- All lanes are independent and identical. The lane count N is only limited by synthesis.

Test Plan:
1. MODE 0, W8F4 to W8F4, inputs 0x90, 0x00, 0x35, 0x01 -> outputs 0x00, 0x00, 0x35, 0x01, each 2 cycles after its handshake, back-to-back with no bubbles.
2. MODE 2, LEAKY_SHIFT=3, inputs 0xF0 (-16), 0xFF (-1), 0x20 -> outputs 0xFE, 0xFF, 0x20.
3. MODE 1, CLIP_INT=6, F_OUT=4, inputs 0x70, 0x60, 0x50, 0xC0 -> outputs 0x60, 0x60, 0x50, 0x00.
4. Requantisation:
   - W8F4 to W8F2, input 0x36 -> 0x0E (13.5 rounds to 14).
   - W8F4 to W4F0, input 0x7F -> 0x7 (8 saturates to 7).
   - W8F4 to W8F6, input 0x30 -> 0x7F (saturated).
5. Backpressure: stream of 6 beats with data_out_0_ready low for 3 cycles mid-stream.
   - data_in_0_ready drops once 2 beats are held.
   - Held output stays stable.
   - All 6 beats emerge in order.
6. TENSOR_DIM_0=8, PAR_0=2 (BEATS=4): 8 beats -> data_out_0_last high on output beats 4 and 8 only. An async reset asserted after beat 2 clears valid and last immediately, and the counter restarts at 0 after release.
